ssd_scan_ctrl: RTL

Parametrised multiplexed seven-segment display controller. It time-multiplexes NUM_DIGITS hex digits, each with a decimal point, onto shared active-low anode and cathode lines. Compared with the basic driver it adds:
- a double-buffered load handshake that commits only at frame boundaries
- per-digit blanking
- leading-zero suppression
- a frame-tick output

It sits between the datapath/debug registers and the board display pins.

---
 rtl/ssd_scan_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: multiplexed seven-segment display scanner.
// Scans NUM_DIGITS hex digits (each with a decimal point) onto shared
// active-low anode/cathode pins. It adds three features to a plain scanner:
//   - a double-buffered load that commits only at frame boundaries
//   - per-digit blanking and leading-zero suppression
//   - a one-cycle frame_tick pulse at each frame boundary
// Optional feature macro: SSD_BRIGHTNESS_EN. It adds a 4-bit brightness input
// that shortens the time each anode is held low within its slot.
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 200000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic                      lz_en,
    input  logic                      load,
`ifdef SSD_BRIGHTNESS_EN
    input  logic [3:0]                brightness,
`endif
    output logic                      pending,
    output logic                      frame_tick,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic [7:0]                cathode
);

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BUF_W = 6 * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] ANODE_RST = ~(NUM_DIGITS'(1));

    // Handshake: load is a strobe with no back-pressure. Every clk edge with
    // load high overwrites the shadow buffer and raises pending. The shadow
    // moves to the active buffer only on a frame-boundary edge, and pending
    // then drops, unless a new load lands on that same edge.
    // Buffer layout: {data[4N-1:0], dp[N-1:0], blank[N-1:0]}.

    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [BUF_W-1:0] shadow, active, active_n;
    logic             slot_end, frame_end;

    logic [4*NUM_DIGITS-1:0] act_data;
    logic [NUM_DIGITS-1:0]   act_dp, act_blank, sup;
    logic                    zero_run;
    logic [3:0]              digit;
    logic                    sel_blank, sel_dp, sel_sup;
    logic [NUM_DIGITS-1:0]   anode_d;
    logic [7:0]              cathode_d;
`ifdef SSD_BRIGHTNESS_EN
    logic [31:0]             thr;
`endif

    // Hex digit to active-low gfedcba segment pattern.
    function automatic logic [6:0] seg7(input logic [3:0] h);
        case (h)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Next slot position and next active buffer. Outputs below are decoded
    // from these, so the pins change on the same edge as idx.
    always_comb begin
        slot_end  = (cnt == CNT_W'(DIV - 1));
        frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
        cnt_n     = slot_end ? '0 : cnt + 1'b1;
        idx_n     = idx;
        if (slot_end) idx_n = frame_end ? '0 : idx + 1'b1;
        active_n  = (frame_end && pending) ? shadow : active;
    end

    // Decode the digit selected for the next cycle into anode/cathode values.
    always_comb begin
        act_data  = active_n[BUF_W-1:2*NUM_DIGITS];
        act_dp    = active_n[2*NUM_DIGITS-1:NUM_DIGITS];
        act_blank = active_n[NUM_DIGITS-1:0];
        // A digit is suppressed when it and every digit above it are zero.
        // Digit 0 is never suppressed, so an all-zero value shows one "0".
        zero_run  = 1'b1;
        sup       = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (act_data[4*k +: 4] == 4'h0);
            sup[k]   = lz_en && zero_run;
        end
        digit     = act_data[4*idx_n +: 4];
        sel_blank = act_blank[idx_n];
        sel_dp    = act_dp[idx_n];
        sel_sup   = sup[idx_n];
        anode_d   = ~(NUM_DIGITS'(1) << idx_n);
`ifdef SSD_BRIGHTNESS_EN
        thr = ((32'(brightness) + 32'd1) * 32'(DIV)) >> 4;
        if (32'(cnt_n) >= thr) anode_d = '1;
`endif
        if (sel_blank) anode_d = '1;
        cathode_d = sel_blank ? 8'hFF : {~sel_dp, (sel_sup ? 7'h7F : seg7(digit))};
    end

    // Slot counter, digit index, shadow/active buffers and pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            cnt    <= cnt_n;
            idx    <= idx_n;
            active <= active_n;
            if (load) begin
                shadow  <= {data_in, dp_in, blank_in};
                pending <= 1'b1;
            end else if (frame_end) begin
                pending <= 1'b0;
            end
        end
    end

    // Registered display pins and the frame pulse, aligned with digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode      <= ANODE_RST;
            cathode    <= 8'hC0;
            frame_tick <= 1'b0;
        end else begin
            anode      <= anode_d;
            cathode    <= cathode_d;
            frame_tick <= frame_end;
        end
    end

endmodule
